// File: rtl/seg7_pkg.sv
// seg7_pkg: segment patterns, FSM encoding, BCD sizing and the double-dabble step
package seg7_pkg;
  localparam int BIN_W = 16;
  localparam int BCD_DIGITS = 5;
  localparam int BCD_W = 4 * BCD_DIGITS;
  localparam int SR_W = BCD_W + BIN_W;
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
  function automatic logic [SR_W-1:0] dabble_step(input logic [SR_W-1:0] s);
    logic [SR_W-1:0] r;
    r = s;
    for (int k = 0; k < BCD_DIGITS; k++)
      if (r[BIN_W+4*k +: 4] >= 4'd5) r[BIN_W+4*k +: 4] = r[BIN_W+4*k +: 4] + 4'd3;
    return {r[SR_W-2:0], 1'b0};
  endfunction
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: seg_of = SEG_0;
      4'd1: seg_of = SEG_1;
      4'd2: seg_of = SEG_2;
      4'd3: seg_of = SEG_3;
      4'd4: seg_of = SEG_4;
      4'd5: seg_of = SEG_5;
      4'd6: seg_of = SEG_6;
      4'd7: seg_of = SEG_7;
      4'd8: seg_of = SEG_8;
      4'd9: seg_of = SEG_9;
      default: seg_of = SEG_BLANK;
    endcase
  endfunction
endpackage

// File: rtl/seg7_sum_display_bin2bcd_seq.sv
// bin2bcd_seq: sequential 16-iteration double-dabble with a one-deep latest-wins pending slot
module bin2bcd_seq
  import seg7_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic [BIN_W-1:0] value,
  input  logic             value_valid,
  output logic [BCD_W-1:0] bcd,
  output logic             commit,
  output logic             busy,
  output logic             done
);
  state_t state, state_nx;
  logic [SR_W-1:0] sr;
  logic [3:0] iter;
  logic pend_v;
  logic [BIN_W-1:0] pend;
  logic load;
  logic [BIN_W-1:0] load_value;
  assign busy = state != IDLE;
  assign commit = state == COMMIT;
  assign bcd = sr[SR_W-1:BIN_W];
  assign load = (state == IDLE && value_valid) || (commit && (pend_v || value_valid));
  // a strobe coinciding with COMMIT is newer than anything pending
  assign load_value = value_valid ? value : pend;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = value_valid ? SHIFT : IDLE;
      SHIFT:   state_nx = iter == 4'd15 ? COMMIT : SHIFT;
      COMMIT:  state_nx = (pend_v || value_valid) ? SHIFT : IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      sr <= '0;
      iter <= '0;
      pend_v <= 1'b0;
      pend <= '0;
      done <= 1'b0;
    end else begin
      state <= state_nx;
      done <= commit;
      if (load) begin
        sr <= {{BCD_W{1'b0}}, load_value};
        iter <= '0;
      end else if (state == SHIFT) begin
        sr <= dabble_step(sr);
        iter <= iter + 4'd1;
      end
      if (commit) pend_v <= 1'b0;
      else if (busy && value_valid) begin
        pend_v <= 1'b1;
        pend <= value;
      end
    end
  end
endmodule

// File: rtl/seg7_sum_display.sv
// seg7_sum_display: converts each new sum to decimal and scans it onto a 4-digit common-anode display
module seg7_sum_display
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic        value_valid,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);
  localparam int CW = $clog2(REFRESH_DIV);
  logic [BCD_W-1:0] bcd;
  logic commit;
  logic [15:0] digits;
  logic [CW-1:0] cnt;
  logic [1:0] idx;
  logic wrap;
  logic blank;
  logic [6:0] seg_nx;
  bin2bcd_seq u_conv (
    .clock(clock),
    .reset(reset),
    .value(value),
    .value_valid(value_valid),
    .bcd(bcd),
    .commit(commit),
    .busy(busy),
    .done(done)
  );
  assign dp = 1'b1;
  assign wrap = cnt == CW'(REFRESH_DIV - 1);
  // shifting out the lower digits leaves only digits idx..3 to test for zero
  assign blank = BLANK_LZ && idx != 2'd0 && (digits >> {idx, 2'b00}) == 16'd0;
  assign seg_nx = overflow ? SEG_DASH : blank ? SEG_BLANK : seg_of(digits[{idx, 2'b00} +: 4]);
  always_ff @(posedge clock) begin
    if (reset) begin
      digits <= '0;
      overflow <= 1'b0;
      cnt <= '0;
      idx <= '0;
      an <= 4'b1111;
      seg <= SEG_BLANK;
    end else begin
      cnt <= wrap ? '0 : cnt + 1'b1;
      if (wrap) idx <= idx + 2'd1;
      an <= ~(4'b0001 << idx);
      seg <= seg_nx;
      if (commit) begin
        digits <= bcd[15:0];
        overflow <= |bcd[19:16];
      end
    end
  end
endmodule

// File: tb/tb_seg7_sum_display.sv
// tb_seg7_sum_display: scoreboard bench driving both blanking variants with directed sums
module tb_seg7_sum_display;
  localparam logic [6:0] K0 = 7'b1000000, K1 = 7'b1111001, K2 = 7'b0100100, K3 = 7'b0110000;
  localparam logic [6:0] K4 = 7'b0011001, K7 = 7'b1111000, K9 = 7'b0010000;
  localparam logic [6:0] KD = 7'b0111111, KB = 7'b1111111;
  typedef struct packed {logic [15:0] d; logic o;} exp_t;
  logic clock = 1'b0, reset = 1'b1, value_valid = 1'b0;
  logic [15:0] value = '0;
  logic busy1, done1, ovf1, dp1, busy0, done0, ovf0, dp0;
  logic [3:0] an1, an0;
  logic [6:0] seg1, seg0;
  exp_t q[$];
  int n_cmp = 0, n_fail = 0;
  always #5 clock = ~clock;
  seg7_sum_display #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) d1 (
    .clock(clock), .reset(reset), .value(value), .value_valid(value_valid),
    .busy(busy1), .done(done1), .overflow(ovf1), .an(an1), .seg(seg1), .dp(dp1));
  seg7_sum_display #(.REFRESH_DIV(4), .BLANK_LZ(1'b0)) d0 (
    .clock(clock), .reset(reset), .value(value), .value_valid(value_valid),
    .busy(busy0), .done(done0), .overflow(ovf0), .an(an0), .seg(seg0), .dp(dp0));
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge clock) begin
    exp_t e;
    if (!reset && done1) begin
      chk("done_expected", q.size() != 0, 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("digits", d1.digits, e.d);
        chk("overflow", ovf1, e.o);
        chk("digits_lz0", d0.digits, e.d);
        chk("done_lz0", done0, 1);
      end
    end
  end
  function automatic logic [1:0] idx_of(input logic [3:0] a);
    return !a[0] ? 2'd0 : !a[1] ? 2'd1 : !a[2] ? 2'd2 : 2'd3;
  endfunction
  task automatic expect_conv(input logic [15:0] ed, input logic eo);
    exp_t e;
    e.d = ed;
    e.o = eo;
    q.push_back(e);
  endtask
  task automatic pulse(input logic [15:0] v);
    @(negedge clock);
    value = v;
    value_valid = 1'b1;
    @(negedge clock);
    value_valid = 1'b0;
  endtask
  task automatic drain();
    for (int i = 0; i < 80 && q.size() != 0; i++) @(negedge clock);
    chk("drain_timeout", q.size(), 0);
    repeat (2) @(negedge clock);
  endtask
  task automatic conv_timed(input logic [15:0] v, input logic [15:0] ed, input logic eo);
    expect_conv(ed, eo);
    pulse(v);
    for (int i = 0; i < 17; i++) begin
      chk("busy_during", busy1, 1);
      chk("no_early_done", done1, 0);
      @(negedge clock);
    end
    chk("done_at_n17", done1, 1);
    chk("idle_after", busy1, 0);
    @(negedge clock);
    chk("done_one_cycle", done1, 0);
    repeat (2) @(negedge clock);
  endtask
  task automatic scan(input logic [27:0] e1, input logic [27:0] e0);
    logic [1:0] i1, i0;
    repeat (16) begin
      @(negedge clock);
      i1 = idx_of(an1);
      i0 = idx_of(an0);
      chk("an1_onehot", $countones(~an1), 1);
      chk("an0_onehot", $countones(~an0), 1);
      chk("seg_lz1", seg1, e1[7*i1 +: 7]);
      chk("seg_lz0", seg0, e0[7*i0 +: 7]);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
  initial begin
    int nd;
    logic [3:0] an_exp;
    repeat (3) @(negedge clock);
    chk("rst_an", an1, 4'b1111);
    chk("rst_seg", seg1, KB);
    chk("rst_dp", dp1, 1);
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_ovf", ovf1, 0);
    reset = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clock);
      an_exp = ~(4'b0001 << (k / 4));
      chk("idle_an", an1, an_exp);
      chk("idle_seg_lz1", seg1, k < 4 ? K0 : KB);
      chk("idle_seg_lz0", seg0, K0);
    end
    conv_timed(16'd1234, 16'h1234, 1'b0);
    scan({K1, K2, K3, K4}, {K1, K2, K3, K4});
    expect_conv(16'h9999, 1'b0);
    pulse(16'd9999);
    drain();
    chk("ovf_9999", ovf1, 0);
    scan({K9, K9, K9, K9}, {K9, K9, K9, K9});
    expect_conv(16'h0000, 1'b1);
    pulse(16'd10000);
    drain();
    chk("ovf_10000", ovf1, 1);
    scan({KD, KD, KD, KD}, {KD, KD, KD, KD});
    expect_conv(16'h5535, 1'b1);
    pulse(16'd65535);
    drain();
    chk("ovf_65535", ovf1, 1);
    scan({KD, KD, KD, KD}, {KD, KD, KD, KD});
    expect_conv(16'h0007, 1'b0);
    pulse(16'd7);
    drain();
    scan({KB, KB, KB, K7}, {K0, K0, K0, K7});
    expect_conv(16'h0100, 1'b0);
    expect_conv(16'h0300, 1'b0);
    pulse(16'd100);
    repeat (2) @(negedge clock);
    value = 16'd200;
    value_valid = 1'b1;
    @(negedge clock);
    value_valid = 1'b0;
    @(negedge clock);
    value = 16'd300;
    value_valid = 1'b1;
    @(negedge clock);
    value_valid = 1'b0;
    nd = 0;
    for (int i = 0; i < 60 && nd < 2; i++) begin
      if (done1) nd++;
      if (nd < 2) chk("busy_no_gap", busy1, 1);
      @(negedge clock);
    end
    chk("pending_dones", nd, 2);
    drain();
    scan({KB, K3, K0, K0}, {K0, K3, K0, K0});
    pulse(16'd5000);
    repeat (7) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("abort_an", an1, 4'b1111);
    chk("abort_seg", seg1, KB);
    chk("abort_busy", busy1, 0);
    chk("abort_done", done1, 0);
    chk("abort_ovf", ovf1, 0);
    @(negedge clock);
    reset = 1'b0;
    nd = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clock);
      if (done1) nd++;
    end
    chk("abort_no_done", nd, 0);
    scan({KB, KB, KB, K0}, {K0, K0, K0, K0});
    conv_timed(16'd42, 16'h0042, 1'b0);
    scan({KB, KB, K4, K2}, {K0, K0, K4, K2});
    chk("queue_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule
